// File: rtl/npu_stream_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : npu_stream_host                                                 |
// | Desc     : Streams an NxN input matrix into the NPU, kicks it, captures    |
// |            the result on done and streams the result bytes back out.       |
// | Options  : NPU_HOST_TIMEOUT_EN - bounded WAIT with sticky error state      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module npu_stream_host #(
    parameter int N              = 10,
    parameter int IN_W           = 16,
    parameter int OUT_W          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [IN_W-1:0]              in_data,
    output logic                                npu_start,
    output logic [N-1:0][N-1:0][IN_W-1:0]       npu_matrix,
    input  logic                                npu_done,
    input  logic [N-1:0][N-1:0][OUT_W-1:0]      npu_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_W-1:0]                    out_data,
    output logic                                out_last,
    output logic                                busy,
    output logic                                error
);

    localparam int               C_IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [C_IW-1:0]  C_LAST = C_IW'(N - 1);
    localparam logic [C_IW-1:0]  C_ONE  = C_IW'(1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_KICK  = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [C_IW-1:0]                  r_row;
    logic [C_IW-1:0]                  r_col;
    logic [N-1:0][N-1:0][IN_W-1:0]    r_matrix;
    logic [N-1:0][N-1:0][OUT_W-1:0]   r_result;

    logic w_at_last;
    logic w_in_fire;
    logic w_out_fire;
    logic w_capture;

    assign w_at_last = (r_row == C_LAST) && (r_col == C_LAST);

`ifdef NPU_HOST_TIMEOUT_EN
    localparam int                C_TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TW-1:0]   C_TO_LAST = C_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [C_TW-1:0]   C_TO_ONE  = C_TW'(1);

    logic [C_TW-1:0] r_wait_cnt;
    logic            w_timeout;

    // Counter is held at zero outside WAIT, so every WAIT entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + C_TO_ONE;
        end
    end

    assign w_timeout = (r_wait_cnt == C_TO_LAST);
`else
    logic [31:0] w_unused_timeout;
    logic        w_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_in_fire   = 1'b0;
        w_out_fire  = 1'b0;
        w_capture   = 1'b0;
        in_ready    = 1'b0;
        npu_start   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        error       = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready  = 1'b1;
                w_in_fire = in_valid;
                if (in_valid && w_at_last) begin
                    w_state_nxt = S_KICK;
                end
            end
            S_KICK: begin
                npu_start   = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // Done takes priority over a timeout landing in the same cycle.
                if (npu_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DRAIN: begin
                out_valid  = 1'b1;
                busy       = 1'b1;
                w_out_fire = out_ready;
                if (out_ready && w_at_last) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_ERR: begin
`ifdef NPU_HOST_TIMEOUT_EN
                error = 1'b1;
`endif
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_LOAD;
            r_row    <= '0;
            r_col    <= '0;
            r_matrix <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_fire) begin
                r_matrix[r_row][r_col] <= in_data;
            end
            if (w_capture) begin
                r_result <= npu_result;
                r_row    <= '0;
                r_col    <= '0;
            end else if (w_in_fire || w_out_fire) begin
                // Row-major walk; wraps to element 0 after the last one.
                if (r_col == C_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == C_LAST) ? '0 : (r_row + C_ONE);
                end else begin
                    r_col <= r_col + C_ONE;
                end
            end
        end
    end

    assign npu_matrix = r_matrix;
    assign out_data   = r_result[r_row][r_col];
    assign out_last   = (r_state == S_DRAIN) && w_at_last;

endmodule
`default_nettype wire

// File: tb/tb_npu_stream_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_npu_stream_host                                              |
// | Desc     : Directed self-checking bench; the bench also plays the NPU.     |
// | Options  : NPU_HOST_TIMEOUT_EN - enables the timeout scenario              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_npu_stream_host;

    localparam int N     = 10;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int NN    = N * N;

    logic                              clk       = 1'b0;
    logic                              rst       = 1'b1;
    logic                              in_valid  = 1'b0;
    logic                              out_ready = 1'b0;
    logic                              npu_done  = 1'b0;
    logic [IN_W-1:0]                   in_data   = '0;
    logic                              in_ready;
    logic                              npu_start;
    logic                              out_valid;
    logic                              out_last;
    logic                              busy;
    logic                              error;
    logic [OUT_W-1:0]                  out_data;
    logic [N-1:0][N-1:0][IN_W-1:0]     npu_matrix;
    logic [N-1:0][N-1:0][OUT_W-1:0]    npu_result;

    logic [7:0]      salt = 8'h00;
    logic [IN_W-1:0] job [NN];
    int              n_pass    = 0;
    int              n_chk     = 0;
    int              start_cnt = 0;

    npu_stream_host #(
        .N              (N),
        .IN_W           (IN_W),
        .OUT_W          (OUT_W),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .npu_start  (npu_start),
        .npu_matrix (npu_matrix),
        .npu_done   (npu_done),
        .npu_result (npu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    // NPU stand-in: result byte is the low byte of each element xor a job salt.
    always_comb begin
        npu_result = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                npu_result[r][c] = npu_matrix[r][c][7:0] ^ salt;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && npu_start) begin
            start_cnt <= start_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int mat_err(input logic zero);
        int e = 0;
        for (int k = 0; k < NN; k++) begin
            if (npu_matrix[k / N][k % N] !== (zero ? 16'h0000 : job[k])) e++;
        end
        return e;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < NN; k++) job[k] = 16'($urandom);
    endtask

    task automatic send(input int n, input int pct);
        int   k     = 0;
        int   guard = 0;
        logic fire;
        while (k < n && guard < 4000) begin
            in_valid = ($urandom_range(99) < pct);
            in_data  = job[k];
            fire     = in_valid && in_ready;
            tick();
            if (fire) k++;
            guard++;
        end
        in_valid = 1'b0;
        chk("send_count", k, n);
    endtask

    task automatic npu_reply(input int lat, input logic [7:0] s);
        repeat (lat) tick();
        salt     = s;
        npu_done = 1'b1;
        chk("no_valid_before_done", out_valid, 0);
        tick();
        npu_done = 1'b0;
        chk("valid_after_done", out_valid, 1);
    endtask

    task automatic recv(input int pct, input logic [7:0] s);
        int   i     = 0;
        int   guard = 0;
        logic fire;
        while (i < NN && guard < 4000) begin
            out_ready = ($urandom_range(99) < pct);
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, job[i][7:0] ^ s);
            chk("drain_last", out_last, (i == NN - 1));
            fire = out_valid && out_ready;
            tick();
            if (fire) i++;
            guard++;
        end
        out_ready = 1'b0;
        chk("recv_count", i, NN);
        chk("idle_after_drain", out_valid, 0);
        chk("ready_after_drain", in_ready, 1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", npu_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_matrix", mat_err(1'b1), 0);
        rst = 1'b0;

        // Job 1: ramp k-50, full-rate both sides
        for (int k = 0; k < NN; k++) job[k] = 16'(k - 50);
        send(NN, 100);
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        chk("j1_kick_start", npu_start, 1);
        chk("j1_kick_busy", busy, 1);
        chk("j1_kick_no_ready", in_ready, 0);
        tick();
        chk("j1_wait_start_low", npu_start, 0);
        chk("j1_wait_no_ready", in_ready, 0);
        in_valid = 1'b0;
        chk("j1_matrix", mat_err(1'b0), 0);
        chk("j1_elem_3_4", npu_matrix[3][4], 16'hFFF0);
        chk("j1_start_cnt", start_cnt, 1);
        npu_reply(18, 8'hA5);
        chk("j1_first_byte", out_data, 8'h6B);
        chk("j1_drain_busy", busy, 1);
        recv(100, 8'hA5);
        chk("j1_start_once", start_cnt, 1);

        // Job 2: random data with sparse valid and ready
        fill_random();
        send(NN, 50);
        chk("j2_kick_start", npu_start, 1);
        npu_reply(20, 8'h5A);
        recv(30, 8'h5A);
        chk("j2_start_cnt", start_cnt, 2);

        // Job 3: done held high through LOAD and KICK must not complete early
        fill_random();
        npu_done = 1'b1;
        salt     = 8'h11;
        send(NN, 100);
        chk("j3_kick_start", npu_start, 1);
        tick();
        chk("j3_stale_done_ignored", out_valid, 0);
        npu_done = 1'b0;
        repeat (5) tick();
        chk("j3_still_waiting", out_valid, 0);
        npu_reply(0, 8'hC3);
        recv(100, 8'hC3);

        // Job 4: reset at element 57, then a full replacement job
        fill_random();
        send(57, 100);
        chk("j4_no_early_start", start_cnt, 3);
        rst = 1'b1;
        tick();
        chk("j4_rst_ready", in_ready, 1);
        chk("j4_rst_busy", busy, 0);
        chk("j4_rst_matrix", mat_err(1'b1), 0);
        rst = 1'b0;
        fill_random();
        send(NN, 100);
        chk("j4_kick_start", npu_start, 1);
        chk("j4_start_not_yet", start_cnt, 3);
        npu_reply(10, 8'h3C);
        chk("j4_matrix", mat_err(1'b0), 0);
        chk("j4_start_cnt", start_cnt, 4);
        recv(100, 8'h3C);

        // Job 5: back-to-back with independent data
        fill_random();
        send(NN, 100);
        npu_reply(3, 8'hE7);
        recv(100, 8'hE7);
        chk("j5_start_cnt", start_cnt, 5);

`ifdef NPU_HOST_TIMEOUT_EN
        // Timeout: done never arrives
        fill_random();
        send(NN, 100);
        chk("to_kick_start", npu_start, 1);
        repeat (64) tick();
        chk("to_wait64_error", error, 0);
        chk("to_wait64_busy", busy, 1);
        tick();
        chk("to_err_error", error, 1);
        chk("to_err_busy", busy, 0);
        chk("to_err_in_ready", in_ready, 0);
        chk("to_err_out_valid", out_valid, 0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        npu_done  = 1'b1;
        repeat (10) tick();
        chk("to_err_sticky", error, 1);
        chk("to_err_in_ready_hold", in_ready, 0);
        chk("to_err_out_valid_hold", out_valid, 0);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        npu_done  = 1'b0;
        chk("to_rst_error", error, 0);
        chk("to_rst_in_ready", in_ready, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/npu_stream_host.md
# npu_stream_host

Host-side stream adapter that drives the `npu` block's matrix interface. It accepts a 10×10 signed 16-bit input matrix as a word stream over a valid/ready handshake and presents it as a parallel matrix. It pulses the NPU start, captures the 8-bit result matrix on done, and streams the 100 result bytes back out over a second valid/ready handshake. It sits between the system bus/DMA side and `npu`, and is the producer and consumer of the NPU's `start`/`done` protocol.

## Interface
- `N`, 10, matrix dimension; elements per job = N*N.
- `IN_W`, 16, input element width (signed).
- `OUT_W`, 8, result element width (unsigned).
- `TIMEOUT_CYCLES`, 4096, maximum WAIT cycles before error (only used with `NPU_HOST_TIMEOUT_EN`).

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  adapter accepts a word this cycle.
- `in_data`  in  IN_W  signed input element, row-major order.
- `npu_start`  out  1  one-cycle start pulse to NPU.
- `npu_matrix`  out  [N][N]×IN_W  signed matrix to NPU `input_matrix`.
- `npu_done`  in  1  NPU completion (pulse or level).
- `npu_result`  in  [N][N]×OUT_W  NPU `final_output`.
- `out_valid`  out  1  result byte valid.
- `out_ready`  in  1  downstream accepts byte.
- `out_data`  out  OUT_W  result element, row-major.
- `out_last`  out  1  high with element N*N-1.
- `busy`  out  1  high in KICK, WAIT, DRAIN.
- `error`  out  1  sticky timeout flag.

## Operation
- FSM states: LOAD, KICK, WAIT, DRAIN, ERR. Reset state: LOAD.
- LOAD: `in_ready`=1. On `in_valid && in_ready`, write `in_data` to `npu_matrix[idx/N][idx%N]` and increment `idx`, a counter of 0..N*N-1. On acceptance of element N*N-1, clear `idx` and go to KICK.
- KICK: `npu_start`=1 for exactly this one cycle. Unconditionally go to WAIT.
- WAIT: hold `npu_matrix` stable. On the first cycle with `npu_done`=1, copy `npu_result` into the internal result buffer, clear `idx`, and go to DRAIN.
- DRAIN: `out_valid`=1 and `out_data`=buffer[idx/N][idx%N]. `out_last` = (idx==N*N-1). On `out_valid && out_ready`, increment `idx`. On the handshake of the last element, clear `idx` and go to LOAD.
- `npu_done` is ignored in LOAD, KICK and DRAIN. A stale done level therefore cannot complete a job early, provided the NPU clears done on start.
- `npu_matrix` keeps the previous job's contents until overwritten element by element in the next LOAD.
- `out_data` and `out_last` must not change while `out_valid && !out_ready`.
- The input side has no backpressure other than `in_ready`. Words offered outside LOAD are not consumed.
- `rst` mid-job from any state: the job is abandoned, state goes to LOAD, `idx`=0, and `error` clears.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `in_ready`=1 (LOAD).
  - `npu_start`=0, `out_valid`=0, `out_last`=0, `busy`=0, `error`=0.
  - `npu_matrix` all 0; result buffer all 0; `out_data`=0.
- While `rst` is high, all outputs are held at their reset values.
- Load throughput: 1 word/cycle; the minimum LOAD phase is N*N cycles.
- Last input accepted at edge T: `npu_start`=1 in cycle T+1, WAIT from T+2.
- `npu_done` sampled at edge D: `out_valid`=1 from cycle D+1.
- Drain throughput: 1 byte/cycle with `out_ready` held high. The next LOAD begins the cycle after the last output handshake.
- Minimum job overhead beyond NPU latency: 1 (KICK) + 1 (capture) cycles.

## Configuration
- `NPU_HOST_TIMEOUT_EN` defined:
  - A WAIT cycle counter resets on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `npu_done`, the FSM goes to ERR.
  - In ERR: `error`=1, `busy`=0, `in_ready`=0, `out_valid`=0.
  - ERR exits only through `rst`.
  - If `npu_done` arrives in the same cycle the count reaches the limit, done wins and the FSM goes to DRAIN.
- Undefined: no counter exists, WAIT is unbounded, ERR is unreachable, and `error` is tied to 0.

## Test plan
- Stream 100 words of value k−50 (k=0..99), `out_ready`=1, NPU model asserts done 20 cycles after start → `npu_matrix[r][c]`=10r+c−50. Exactly one `npu_start` pulse. 100 bytes out in row-major order with `out_last` only on byte 99.
- `in_valid` random at 50% and `out_ready` random at 30% → no lost or duplicated elements. `out_data` stable while stalled. Total accepted and emitted are both exactly 100.
- Hold `npu_done`=1 through LOAD and KICK, drop it for 5 cycles in WAIT, then raise it → capture occurs only after the rise in WAIT. Results match the model value at that cycle.
- Assert `rst` for 1 cycle at input element 57, then load a full new job → the first job is discarded. `npu_start` pulses only once, after the new 100th word. Outputs match the new job.
- With `NPU_HOST_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, never assert done → `error`=1 after 64 WAIT cycles. `in_ready` and `out_valid` stay 0 until `rst`, then `error`=0 and `in_ready`=1.
- Back-to-back jobs with `out_ready`=1 → `in_ready` rises the cycle after byte 99 is accepted. The second job's results are independent of the first.
